alu_unit: RTL
=============

# alu_unit

Integer execution unit sitting downstream of the reservation station. It accepts one dispatched operation per cycle (operands, immediate, packed op code, RoB tag) and computes the result in one cycle. Results go into a small in-order result queue, which drives the common data bus toward the RoB and the RS/LSB wake-up logic. It returns a completion pulse to the RS so the RS can free the issuing entry, and it is flushed by the RoB clear.

## Interface
Parameters:
- ROB_BITS, 4, width of RoB tag
- QDEPTH, 2, result queue depth (power of two, ≥2)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-high
- rdy_in  input  1  global enable; when low, no state changes
- clear  input  1  RoB flush; synchronous, drops all queued results
- in_valid  input  1  RS dispatch strobe
- in_ready  output  1  queue can take an op this cycle
- in_vj  input  32  operand 1
- in_vk  input  32  operand 2 (valid for B/R ops)
- in_imm  input  32  immediate; AUIPC already carries pc+imm
- in_op  input  6  {funct7 bit, funct3[2:0], type[1:0]}; type 0=U, 1=I, 2=B, 3=R; 6'b111111=J
- in_id  input  ROB_BITS  destination RoB tag
- out_valid  output  1  head result present on CDB
- out_id  output  ROB_BITS  head result tag
- out_value  output  32  head result value
- out_grant  input  1  CDB arbiter accepted head this cycle
- finish_rdy  output  1  equals out_valid && out_grant; the RS frees the entry on it

## Operation
- Accept: a dispatch is accepted when in_valid && in_ready && rdy_in && !clear. The result is computed combinationally from the inputs and pushed into the queue at that clock edge.
- in_ready = (count < QDEPTH). There is no same-cycle pop bypass, so a full queue refuses input even while the head is being granted.
- Pop: out_valid && out_grant && rdy_in. The queue advances to the next entry.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- The queue is a circular buffer with head/tail pointers of log2(QDEPTH) bits that wrap naturally, plus a count of log2(QDEPTH)+1 bits.
- Results by type:
  - U: imm.
  - J: imm.
  - I: ALU(vj, imm). The funct7 bit is honoured only when funct3=101 (srai vs srli); for all other funct3 it is ignored.
  - R: ALU(vj, vk). The funct7 bit selects sub for funct3=000 and sra for funct3=101.
  - B: 32-bit 0/1 taken flag. funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 yield 0.
- ALU by funct3:
  - 000 add/sub
  - 001 sll
  - 010 slt (signed)
  - 011 sltu
  - 100 xor
  - 101 srl/sra
  - 110 or
  - 111 and
- Shift amount is the second operand [4:0]. Arithmetic is modulo 2^32. sra sign-fills.
- clear (with rdy_in high): count, head and tail go to 0, any same-cycle dispatch is dropped, and no pop is counted.
- rdy_in low: every register holds. finish_rdy still follows out_valid && out_grant combinationally; the arbiter must not grant while rdy_in is low.

## Timing
- Reset: count/head/tail = 0, so out_valid=0, finish_rdy=0 and in_ready=1. Queue data is reset to 0, so out_id=0 and out_value=0.
- Latency: an op accepted at edge N is visible on out_* from cycle N+1. With out_grant held high, one result per cycle is sustained.
- out_* are stable while out_valid=1 and out_grant=0.
- clear at edge N: out_valid=0 from cycle N+1, and in_ready=1.
- Reset asserted mid-operation: outputs go to reset values immediately, with no clock needed.

## Test plan
- R add: vj=5, vk=7, op={0,000,11}, id=3, grant=1 → the next cycle gives out_valid=1, out_id=3, out_value=12, finish_rdy=1; the cycle after that gives out_valid=0.
- Sub/sra/I-type funct7 masking:
  - R sub 3−5 → 0xFFFFFFFE.
  - R sra 0x80000000>>4 → 0xF8000000.
  - I addi with funct7 bit=1, vj=1, imm=0xFFFFFFFF → 0 (no subtract).
- Branch:
  - blt vj=0xFFFFFFFF, vk=1 → 1.
  - bltu same operands → 0.
  - bne equal operands → 0.
- Backpressure: out_grant=0, dispatch ids 1, 2, 3 on consecutive cycles → id 3 is refused (in_ready=0 after two pushes). Then raise out_grant → ids 1, 2 emerge in order; in_ready returns to 1 the cycle after the first pop.
- Flush: queue holding 2 results, clear=1 together with in_valid → next cycle out_valid=0, in_ready=1, and the dropped dispatch never appears.
- Stall/reset:
  - rdy_in=0 with in_valid=1 → no push, and the queue holds its state.
  - Asynchronous rst_in pulse between clock edges while out_valid=1 → out_valid falls immediately and out_value=0.

Source files
------------

// File: rtl/alu_unit.sv
// Single-cycle integer execution unit with an in-order result queue feeding the CDB.
// Results are computed combinationally at dispatch and buffered until the arbiter grants the head.
module alu_unit #(
  parameter int ROB_BITS = 4,
  parameter int QDEPTH   = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_vj,
  input  logic [31:0]         in_vk,
  input  logic [31:0]         in_imm,
  input  logic [5:0]          in_op,
  input  logic [ROB_BITS-1:0] in_id,
  output logic                out_valid,
  output logic [ROB_BITS-1:0] out_id,
  output logic [31:0]         out_value,
  input  logic                out_grant,
  output logic                finish_rdy
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW:0] DEPTH = (PW + 1)'(QDEPTH);

  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [PW:0]         count_q, count_d;
  logic [31:0]         value_q [QDEPTH];
  logic [31:0]         value_d [QDEPTH];
  logic [ROB_BITS-1:0] id_q [QDEPTH];
  logic [ROB_BITS-1:0] id_d [QDEPTH];

  logic [1:0]  op_type;
  logic [2:0]  funct3;
  logic        funct7;
  logic        taken;
  logic [31:0] result;
  logic        push;
  logic        pop;

  function automatic logic [31:0] alu_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic alt);
    logic [4:0]         sh;
    logic signed [31:0] sra_v;
    sh     = b[4:0];
    sra_v  = $signed(a) >>> sh;
    alu_op = 32'd0;
    case (f3)
      3'b000:  alu_op = alt ? (a - b) : (a + b);
      3'b001:  alu_op = a << sh;
      3'b010:  alu_op = {31'd0, $signed(a) < $signed(b)};
      3'b011:  alu_op = {31'd0, a < b};
      3'b100:  alu_op = a ^ b;
      3'b101:  alu_op = alt ? sra_v : (a >> sh);
      3'b110:  alu_op = a | b;
      default: alu_op = a & b;
    endcase
  endfunction

  assign op_type = in_op[1:0];
  assign funct3  = in_op[4:2];
  assign funct7  = in_op[5];

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (in_vj == in_vk);
      3'b001:  taken = (in_vj != in_vk);
      3'b100:  taken = ($signed(in_vj) < $signed(in_vk));
      3'b101:  taken = !($signed(in_vj) < $signed(in_vk));
      3'b110:  taken = (in_vj < in_vk);
      3'b111:  taken = !(in_vj < in_vk);
      default: taken = 1'b0;
    endcase
  end

  // J shares type bits with R, so it must be decoded before the type switch
  always_comb begin
    result = in_imm;
    if (in_op != 6'b111111) begin
      case (op_type)
        2'd0:    result = in_imm;
        2'd1:    result = alu_op(in_vj, in_imm, funct3, funct7 && (funct3 == 3'b101));
        2'd2:    result = {31'd0, taken};
        default: result = alu_op(in_vj, in_vk, funct3, funct7);
      endcase
    end
  end

  assign in_ready   = (count_q < DEPTH);
  assign out_valid  = (count_q != '0);
  assign out_id     = id_q[head_q];
  assign out_value  = value_q[head_q];
  assign finish_rdy = out_valid && out_grant;

  assign push = in_valid && in_ready && rdy_in && !clear;
  assign pop  = out_valid && out_grant && rdy_in && !clear;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    value_d = value_q;
    id_d    = id_q;
    if (rdy_in && clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        value_d[tail_q] = result;
        id_d[tail_q]    = in_id;
        tail_d          = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      value_q <= '{default: '0};
      id_q    <= '{default: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      value_q <= value_d;
      id_q    <= id_d;
    end
  end

endmodule
